// File: rtl/pixel_xform_pkg.sv
// Shared types and CSR layout for the pixel transform DMA engine.
package pixel_xform_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PASS    = 2'd0,
        INVERT  = 2'd1,
        ADD_SAT = 2'd2,
        THRESH  = 2'd3
    } mode_t;

    localparam logic [1:0] CSR_CTRL  = 2'd0;
    localparam logic [1:0] CSR_SRC   = 2'd1;
    localparam logic [1:0] CSR_DST   = 2'd2;
    localparam logic [1:0] CSR_COUNT = 2'd3;

    // CTRL write fields
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_IRQEN_BIT = 1;
    localparam int CTRL_MODE_LSB  = 8;
    localparam int CTRL_K_LSB     = 16;

    // STATUS read fields (mode and k share the CTRL positions)
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_IRQEN_BIT = 2;

endpackage

// File: rtl/pixel_xform_lane.sv
// Combinational transform of one 8-bit pixel.
module pixel_xform_lane
    import pixel_xform_pkg::*;
(
    input  logic [7:0] p,
    input  logic [7:0] k,
    input  mode_t      mode,
    output logic [7:0] q
);

    logic [8:0] sum;

    always_comb begin
        sum = {1'b0, p} + {1'b0, k};
        case (mode)
            PASS:    q = p;
            INVERT:  q = ~p;
            ADD_SAT: q = sum[8] ? 8'hFF : sum[7:0];
            THRESH:  q = (p >= k) ? 8'hFF : 8'h00;
            default: q = p;
        endcase
    end

endmodule

// File: rtl/pixel_xform_dma.sv
// Avalon-MM pixel transform engine: reads source words, transforms each byte,
// writes results to the destination buffer, one read outstanding at a time.
//
//   state   | meaning
//   --------+------------------------------------------------
//   IDLE    | waiting for a CTRL write with start=1
//   RD_REQ  | m_read asserted at src_ptr until accepted
//   RD_WAIT | waiting for m_readdatavalid, captures transform
//   WR_REQ  | m_write asserted at dst_ptr until accepted
//   DONE    | one cycle; done set, busy clear
module pixel_xform_dma
    import pixel_xform_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int MAX_COUNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        s_address,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [31:0]       s_writedata,
    output logic [31:0]       s_readdata,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic [3:0]        m_byteenable,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid,
    input  logic              m_waitrequest,
    output logic              irq
);

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      src_q, src_d, dst_q, dst_d;
    logic [ADDR_W-1:0]      src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
    logic [MAX_COUNT_W-1:0] count_q, count_d, remain_q, remain_d;
    mode_t                  mode_q, mode_d;
    logic [7:0]             k_q, k_d;
    logic                   irq_en_q, irq_en_d, done_q, done_d;
    logic [31:0]            data_q, data_d, rdata_q, rdata_d;
    logic [31:0]            xform_word, status_word;
    logic                   busy, ctrl_wr;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        pixel_xform_lane u_lane (
            .p    (m_readdata[8*i +: 8]),
            .k    (k_q),
            .mode (mode_q),
            .q    (xform_word[8*i +: 8])
        );
    end

    assign busy    = (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == WR_REQ);
    assign ctrl_wr = s_write && (s_address == CSR_CTRL) && !busy;

    always_comb begin
        status_word                         = '0;
        status_word[STAT_BUSY_BIT]          = busy;
        status_word[STAT_DONE_BIT]          = done_q;
        status_word[STAT_IRQEN_BIT]         = irq_en_q;
        status_word[CTRL_MODE_LSB +: 2]     = mode_q;
        status_word[CTRL_K_LSB +: 8]        = k_q;
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        count_d   = count_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        remain_d  = remain_q;
        mode_d    = mode_q;
        k_d       = k_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        data_d    = data_q;
        rdata_d   = rdata_q;

        if (s_write && !busy) begin
            case (s_address)
                CSR_SRC:   src_d   = ADDR_W'(s_writedata);
                CSR_DST:   dst_d   = ADDR_W'(s_writedata);
                CSR_COUNT: count_d = MAX_COUNT_W'(s_writedata);
                default:   ;
            endcase
        end

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (ctrl_wr) begin
                    done_d = 1'b0;
                    if (s_writedata[CTRL_START_BIT]) begin
                        mode_d    = mode_t'(s_writedata[CTRL_MODE_LSB +: 2]);
                        k_d       = s_writedata[CTRL_K_LSB +: 8];
                        irq_en_d  = s_writedata[CTRL_IRQEN_BIT];
                        src_ptr_d = src_q;
                        dst_ptr_d = dst_q;
                        remain_d  = count_q;
                        state_d   = (count_q == '0) ? DONE : RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (!m_waitrequest) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (m_readdatavalid) begin
                    data_d  = xform_word;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (!m_waitrequest) begin
                    src_ptr_d = src_ptr_q + ADDR_W'(4);
                    dst_ptr_d = dst_ptr_q + ADDR_W'(4);
                    remain_d  = remain_q - MAX_COUNT_W'(1);
                    state_d   = (remain_q == MAX_COUNT_W'(1)) ? DONE : RD_REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // done is visible from the DONE cycle onward so irq follows the last write
        if (state_d == DONE) done_d = 1'b1;

        if (s_read) begin
            case (s_address)
                CSR_CTRL:  rdata_d = status_word;
                CSR_SRC:   rdata_d = 32'(src_q);
                CSR_DST:   rdata_d = 32'(dst_q);
                CSR_COUNT: rdata_d = 32'(count_q);
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            count_q   <= '0;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            remain_q  <= '0;
            mode_q    <= PASS;
            k_q       <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            count_q   <= count_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            remain_q  <= remain_d;
            mode_q    <= mode_d;
            k_q       <= k_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            data_q    <= data_d;
            rdata_q   <= rdata_d;
        end
    end

    assign m_read       = (state_q == RD_REQ);
    assign m_write      = (state_q == WR_REQ);
    assign m_address    = (state_q == RD_REQ) ? src_ptr_q :
                          (state_q == WR_REQ) ? dst_ptr_q : '0;
    assign m_writedata  = data_q;
    assign m_byteenable = 4'hF;
    assign irq          = done_q & irq_en_q;
    assign s_readdata   = rdata_q;

endmodule

// File: tb/tb_pixel_xform_dma.sv
// Scoreboard bench for pixel_xform_dma: a memory slave model serves reads,
// expected writes and CSR reads are queued and checked by a monitor.
module tb_pixel_xform_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  s_address;
    logic        s_read, s_write;
    logic [31:0] s_writedata, s_readdata;
    logic [31:0] m_address;
    logic        m_read, m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic [31:0] m_readdata;
    logic        m_readdatavalid, m_waitrequest;
    logic        irq;

    pixel_xform_dma #(.ADDR_W(32), .MAX_COUNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_readdata      (s_readdata),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .m_waitrequest   (m_waitrequest),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] csr_q[$];
    logic [31:0] mem [logic [31:0]];

    int total_cnt = 0, pass_cnt = 0;
    int wait_cfg = 0, lat_cfg = 1;
    int rd_cnt = 0, wr_cnt = 0, overlap_cnt = 0, stab_viol = 0, stall_seen = 0;
    bit inject_rdv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory slave: stalls each request wait_cfg cycles, returns data lat_cfg cycles after grant.
    initial begin
        int          stall;
        bit          req_active;
        int          rd_wait;
        logic [31:0] rd_data;
        stall = 0; req_active = 1'b0; rd_wait = 0; rd_data = '0;
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
        forever begin
            @(posedge clk); #1;
            m_readdatavalid = 1'b0;
            if (rst) begin
                stall = 0; req_active = 1'b0; rd_wait = 0; m_waitrequest = 1'b0;
                continue;
            end
            if (inject_rdv) begin
                m_readdatavalid = 1'b1;
                m_readdata      = 32'hDEAD_BEEF;
                inject_rdv      = 1'b0;
            end
            if (rd_wait > 0) begin
                rd_wait--;
                if (rd_wait == 0) begin
                    m_readdatavalid = 1'b1;
                    m_readdata      = rd_data;
                end
            end
            if (m_read || m_write) begin
                if (!req_active) begin
                    req_active = 1'b1;
                    stall      = wait_cfg;
                end
                if (stall > 0) begin
                    m_waitrequest = 1'b1;
                    stall--;
                end else begin
                    m_waitrequest = 1'b0;
                    req_active    = 1'b0;
                    if (m_read) begin
                        rd_data = mem.exists(m_address) ? mem[m_address] : 32'h0;
                        rd_wait = lat_cfg;
                    end
                end
            end else begin
                m_waitrequest = 1'b0;
                req_active    = 1'b0;
            end
        end
    end

    // Monitor: CSR readback, write scoreboard, protocol counters.
    initial begin
        bit          csr_pend, prev_st;
        logic [31:0] pa, pd;
        logic        pr, pw;
        wr_t         e;
        csr_pend = 1'b0; prev_st = 1'b0; pa = '0; pd = '0; pr = 1'b0; pw = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                csr_pend = 1'b0;
                prev_st  = 1'b0;
                continue;
            end
            if (csr_pend) begin
                if (csr_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL csr_read: got %h with no expected value queued", s_readdata);
                end else begin
                    check("csr_read", s_readdata, csr_q.pop_front());
                end
            end
            csr_pend = s_read;
            if (m_read && m_write) overlap_cnt++;
            if (prev_st && (m_read || m_write) &&
                ({m_address, m_writedata, m_read, m_write} != {pa, pd, pr, pw}))
                stab_viol++;
            prev_st = (m_read || m_write) && m_waitrequest;
            if (prev_st) stall_seen++;
            pa = m_address; pd = m_writedata; pr = m_read; pw = m_write;
            if (m_read && !m_waitrequest) rd_cnt++;
            if (m_write && !m_waitrequest) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL bus_write: got write %h @%h with none expected", m_writedata, m_address);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", m_address, e.addr);
                    check("wr_data", m_writedata, e.data);
                end
            end
        end
    end

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        s_address = a; s_writedata = d; s_write = 1'b1;
        @(posedge clk); #1;
        s_write = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] a, input logic [31:0] exp);
        csr_q.push_back(exp);
        s_address = a; s_read = 1'b1;
        @(posedge clk); #1;
        s_read = 1'b0;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic run(input logic [31:0] src, input logic [31:0] dst,
                       input logic [31:0] cnt, input logic [31:0] ctrl);
        csr_write(2'd1, src);
        csr_write(2'd2, dst);
        csr_write(2'd3, cnt);
        csr_write(2'd0, ctrl);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !m_read && !m_write) break;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        rst = 1'b1; s_address = '0; s_read = 1'b0; s_write = 1'b0; s_writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_readdata", s_readdata, 32'h0);
        check("rst_m_read", 32'(m_read), 32'h0);
        check("rst_m_write", 32'(m_write), 32'h0);
        check("rst_m_address", m_address, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_byteenable", 32'(m_byteenable), 32'hF);
        rst = 1'b0;
        @(posedge clk); #1;
        csr_read(2'd0, 32'h0);

        // 1: invert, two words
        mem[32'h1000] = 32'h00FF1080;
        mem[32'h1004] = 32'h01020304;
        expect_wr(32'h2000, 32'hFF00EF7F);
        expect_wr(32'h2004, 32'hFEFDFCFB);
        run(32'h1000, 32'h2000, 32'd2, 32'h0000_0101);
        wait_drain();
        csr_read(2'd0, 32'h0000_0102);
        check("t1_irq", 32'(irq), 32'h0);

        // 2: saturating add k=0x20
        mem[32'h1100] = 32'hF0E01000;
        expect_wr(32'h2100, 32'hFFFF3020);
        run(32'h1100, 32'h2100, 32'd1, 32'h0020_0201);
        wait_drain();
        csr_read(2'd0, 32'h0020_0202);

        // 3: threshold k=0x80 with irq
        mem[32'h1200] = 32'h7F80FF00;
        expect_wr(32'h2200, 32'h00FFFF00);
        run(32'h1200, 32'h2200, 32'd1, 32'h0080_0303);
        check("t3_irq_busy", 32'(irq), 32'h0);
        wait_drain();
        check("t3_irq_done", 32'(irq), 32'h1);
        csr_read(2'd0, 32'h0080_0306);
        csr_write(2'd0, 32'h0);
        check("t3_irq_clear", 32'(irq), 32'h0);
        csr_read(2'd0, 32'h0080_0304);

        // 4: stalls and long read latency
        wait_cfg = 3; lat_cfg = 5;
        rd_cnt = 0; wr_cnt = 0; overlap_cnt = 0; stab_viol = 0; stall_seen = 0;
        mem[32'h3000] = 32'h11223344;
        mem[32'h3004] = 32'hA5A5A5A5;
        mem[32'h3008] = 32'hDEADBEEF;
        expect_wr(32'h4000, 32'h11223344);
        expect_wr(32'h4004, 32'hA5A5A5A5);
        expect_wr(32'h4008, 32'hDEADBEEF);
        run(32'h3000, 32'h4000, 32'd3, 32'h0000_0001);
        wait_drain();
        check("t4_reads", 32'(rd_cnt), 32'd3);
        check("t4_writes", 32'(wr_cnt), 32'd3);
        check("t4_overlap", 32'(overlap_cnt), 32'd0);
        check("t4_stable", 32'(stab_viol), 32'd0);
        check("t4_stall_cycles", 32'(stall_seen), 32'd18);
        wait_cfg = 0; lat_cfg = 1;

        // 5: COUNT=0, then ignored restart during a 4-word run
        rd_cnt = 0; wr_cnt = 0;
        run(32'h1000, 32'h2000, 32'd0, 32'h0000_0001);
        csr_read(2'd0, 32'h0000_0002);
        repeat (5) @(posedge clk);
        #1;
        check("t5_zero_reads", 32'(rd_cnt), 32'd0);
        check("t5_zero_writes", 32'(wr_cnt), 32'd0);
        mem[32'h7000] = 32'h00000000;
        mem[32'h7004] = 32'hFFF00F01;
        mem[32'h7008] = 32'h12345678;
        mem[32'h700C] = 32'hEFEEF000;
        expect_wr(32'h8000, 32'h10101010);
        expect_wr(32'h8004, 32'hFFFF1F11);
        expect_wr(32'h8008, 32'h22446688);
        expect_wr(32'h800C, 32'hFFFEFF10);
        run(32'h7000, 32'h8000, 32'd4, 32'h0010_0201);
        csr_write(2'd0, 32'h00FF_0301);
        csr_write(2'd3, 32'd9);
        wait_drain();
        check("t5_reads", 32'(rd_cnt), 32'd4);
        check("t5_writes", 32'(wr_cnt), 32'd4);
        csr_read(2'd0, 32'h0010_0202);
        csr_read(2'd3, 32'd4);

        // 6: reset during the second write of four
        wait_cfg = 3; lat_cfg = 2;
        rd_cnt = 0; wr_cnt = 0;
        mem[32'h5000] = 32'h01010101;
        mem[32'h5004] = 32'h02020202;
        mem[32'h5008] = 32'h03030303;
        mem[32'h500C] = 32'h04040404;
        expect_wr(32'h6000, 32'h01010101);
        expect_wr(32'h6004, 32'h02020202);
        expect_wr(32'h6008, 32'h03030303);
        expect_wr(32'h600C, 32'h04040404);
        run(32'h5000, 32'h6000, 32'd4, 32'h0000_0001);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #2;
            if (wr_cnt == 1 && m_write && m_waitrequest) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_reach_wr2", 32'(found), 32'h1);
        rst = 1'b1;
        #1;
        check("t6_rst_m_write", 32'(m_write), 32'h0);
        check("t6_rst_m_read", 32'(m_read), 32'h0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_cfg = 0; lat_cfg = 1;
        inject_rdv = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("t6_writes", 32'(wr_cnt), 32'd1);
        check("t6_reads", 32'(rd_cnt), 32'd2);
        csr_read(2'd0, 32'h0);
        csr_read(2'd1, 32'h0);
        csr_read(2'd3, 32'h0);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pixel_xform_dma.md
Name: pixel_xform_dma

Overview:
Avalon-MM pixel transform engine for the pixel_xform_system. It is the master side of the bus: it reads a source buffer of packed 8-bit pixels from memory, transforms each byte, and writes the results to a destination buffer. The Nios controls it through a small Avalon-MM slave register port. Completion is reported through a status register and an optional irq.

Parameters:
ADDR_W, 32, master address width (byte addresses)
MAX_COUNT_W, 16, width of the word-count register

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
s_address  in  2  CSR word index
s_read  in  1  CSR read strobe
s_write  in  1  CSR write strobe
s_writedata  in  32  CSR write data
s_readdata  out  32  CSR read data (valid the cycle after s_read)
m_address  out  ADDR_W  master byte address
m_read  out  1  master read request
m_write  out  1  master write request
m_writedata  out  32  master write data
m_byteenable  out  4  always 4'hF
m_readdata  in  32  master read data
m_readdatavalid  in  1  read data valid
m_waitrequest  in  1  slave stall
irq  out  1  level interrupt; equals done AND irq_en

Behaviour:
- CSR map:
  - 0 CTRL/STATUS. Write: bit0 start, bit1 irq_en, bits[9:8] mode, bits[23:16] k. Read: bit0 busy, bit1 done, bit2 irq_en, bits[9:8] mode, bits[23:16] k.
  - 1 SRC base address.
  - 2 DST base address.
  - 3 COUNT in 32-bit words (MAX_COUNT_W LSBs).
- CSR write side effects:
  - A write to 0 clears done.
  - A write to 0 with start=1 while idle latches mode/k/irq_en and starts a run.
  - A write to 0 while busy is ignored entirely.
  - Writes to 1-3 while busy are ignored.
- Reset value of every output and register: 0. This includes s_readdata, m_read, m_write, m_address, irq, busy and done. m_byteenable is the constant 4'hF.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE -> RD_REQ on a valid start with COUNT≠0.
  - With COUNT=0, go IDLE -> DONE for one cycle. done sets, and there is no bus traffic.
- RD_REQ: assert m_read with m_address = src_ptr.
  - Hold both stable while m_waitrequest=1.
  - Go to RD_WAIT on the first cycle with m_waitrequest=0.
- RD_WAIT: wait for m_readdatavalid (any latency ≥1). Capture the transformed word, then go to WR_REQ.
- WR_REQ: assert m_write with m_address = dst_ptr and m_writedata = captured word.
  - Hold while m_waitrequest=1.
  - On acceptance: src_ptr += 4, dst_ptr += 4, remaining -= 1.
  - If remaining reaches 0, go to DONE; otherwise go to RD_REQ.
- DONE: set done, clear busy, go to IDLE.
  - done stays set until the next CTRL write.
  - busy is 1 in every state except IDLE and DONE.
- Only one read is outstanding at a time. m_read and m_write are never asserted together.
- Transform, applied independently to each byte p of the word:
  - mode 0 pass: p.
  - mode 1 invert: 255-p.
  - mode 2 saturating add: min(p+k, 255), computed 9 bits wide.
  - mode 3 threshold: p≥k ? 255 : 0.
- Address arithmetic wraps modulo 2^ADDR_W. No alignment checking; the low 2 bits are passed through as written.
- rst mid-run drops m_read/m_write in the same instant and returns the engine to IDLE with all registers cleared. Any in-flight readdatavalid arriving after reset is ignored.
- m_readdatavalid outside RD_WAIT is ignored.
- s_readdata is registered and updated only on s_read; otherwise it holds its last value.

Decomposition:
- pixel_xform_pkg:
  - state_t enum (IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE).
  - mode_t enum (PASS, INVERT, ADD_SAT, THRESH).
  - CSR offset constants (CSR_CTRL=0, CSR_SRC=1, CSR_DST=2, CSR_COUNT=3).
  - CTRL bit-position localparams.
- Sub-module pixel_xform_lane: combinational single-byte transform (p, k, mode -> q). Instantiated 4 times in a generate loop.

Test Plan:
1. SRC=0x1000, DST=0x2000, COUNT=2, mode 1, memory words 0x00FF1080 and 0x01020304, no waitrequest.
   -> Writes 0xFF00EF7F @0x2000 and 0xFEFDFCFB @0x2004. done=1, busy=0.
2. Mode 2, k=0x20, word 0xF0E01000.
   -> Writes 0xFFFF3020, showing saturation on the two top bytes.
3. Mode 3, k=0x80, word 0x7F80FF00.
   -> Writes 0x00FFFF00. With irq_en=1, irq rises after the final write; a CTRL write with start=0 clears done and irq.
4. m_waitrequest held high 3 cycles on every request and readdatavalid latency 5.
   -> Address/data stable while stalled, exactly COUNT reads and COUNT writes, no overlap of m_read and m_write.
5. COUNT=0 start.
   -> No m_read/m_write ever asserted; done=1 within 2 cycles. A second start issued while busy on a COUNT=4 run is ignored, and exactly 4 words are written.
6. Assert rst during WR_REQ of word 2 of 4.
   -> m_write=0 immediately, STATUS reads 0, no further bus traffic; a late readdatavalid pulse is ignored.
